// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin-change payout FSM with a timed request/ack handshake to a coin hopper.
// Build option: define CHANGE_50_EN to enable the 50-unit denomination.
module change_dispenser #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] amount,
    input  logic       coin_ack,
    input  logic [3:0] hopper_empty,
    output logic       coin_req,
    output logic [1:0] coin_type,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [9:0] remaining,
    output logic [7:0] total_coins
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SELECT = 3'd1;
    localparam logic [2:0] REQ    = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;
    localparam logic [2:0] ERR    = 3'd4;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

    logic [2:0]    state;
    logic [CW-1:0] wait_cnt;
    logic          use_50, use_10, use_5, use_1;
    logic [1:0]    pick;
    logic [9:0]    coin_value;

`ifdef CHANGE_50_EN
    assign use_50 = !hopper_empty[3] && remaining >= 10'd50;
`else
    assign use_50 = 1'b0 && hopper_empty[3];
`endif
    assign use_10 = !hopper_empty[2] && remaining >= 10'd10;
    assign use_5  = !hopper_empty[1] && remaining >= 10'd5;
    assign use_1  = !hopper_empty[0] && remaining != 10'd0;
    assign pick   = use_50 ? 2'd3 : use_10 ? 2'd2 : use_5 ? 2'd1 : 2'd0;

    assign coin_value = coin_type == 2'd3 ? 10'd50 : coin_type == 2'd2 ? 10'd10 :
                        coin_type == 2'd1 ? 10'd5 : 10'd1;

    assign coin_req = state == REQ;
    assign busy     = state == SELECT || state == REQ;
    assign done     = state == DONE;
    assign error    = state == ERR;

    // Payout sequencing: latch on start, pick a coin, wait for the hopper ack or time out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            coin_type   <= 2'd0;
            remaining   <= 10'd0;
            total_coins <= 8'd0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE, ERR: if (start) begin
                    state       <= SELECT;
                    remaining   <= amount;
                    total_coins <= 8'd0;
                end
                SELECT: begin
                    wait_cnt  <= '0;
                    coin_type <= pick;
                    state     <= remaining == 10'd0 ? DONE :
                                 (use_50 || use_10 || use_5 || use_1) ? REQ : ERR;
                end
                REQ: if (coin_ack) begin
                    remaining   <= remaining - coin_value;
                    total_coins <= total_coins + {7'd0, total_coins != 8'hFF};
                    state       <= SELECT;
                end else if (wait_cnt == LAST) begin
                    state <= ERR;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
